// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store initiator for a word-addressed memory with a registered read.
// Defining LSU_RMW_EN enables sub-word stores through read-modify-write.
// Without it, byte and half stores are rejected with an error.
module load_store_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [WIDTH-1:0] Address,
    output logic [WIDTH-1:0] WriteData,
    input  logic [WIDTH-1:0] ReadData
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WRITE, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_addr, r_wdata, r_rdata, w_idx, w_ext, w_wdata;
    logic [1:0]       r_size;
    logic             r_uns, r_write, r_err, w_hs, w_err, w_rmw_rej;
    logic [4:0]       w_shamt;
    logic [15:0]      w_lane;

    assign w_hs    = req_valid & req_ready;
    assign w_idx   = req_addr >> 2;
`ifdef LSU_RMW_EN
    assign w_rmw_rej = 1'b0;
`else
    assign w_rmw_rej = req_write & ~req_size[1];
`endif
    assign w_err   = (req_size == 2'b11) | ((req_size == 2'b01) & req_addr[0]) |
                     ((req_size == 2'b10) & |req_addr[1:0]) | (w_idx >= WIDTH'(DEPTH)) | w_rmw_rej;
    assign w_shamt = {r_addr[1:0], 3'b000};
    assign w_lane  = 16'(ReadData >> w_shamt);
    assign w_ext   = (r_size == 2'b00) ? {{(WIDTH-8){w_lane[7] & ~r_uns}}, w_lane[7:0]} :
                     (r_size == 2'b01) ? {{(WIDTH-16){w_lane[15] & ~r_uns}}, w_lane[15:0]} : ReadData;

`ifdef LSU_RMW_EN
    logic [WIDTH-1:0] r_word, w_mask, w_merge;
    assign w_mask  = (r_size[0] ? WIDTH'(16'hFFFF) : WIDTH'(8'hFF)) << w_shamt;
    assign w_merge = (r_word & ~w_mask) | ((r_wdata << w_shamt) & w_mask);
    assign w_wdata = r_size[1] ? r_wdata : w_merge;

    // Keep the word read back in RD_WAIT for merging with the store lane.
    always_ff @(posedge clk) begin
        if (!rst_n) r_word <= '0;
        else if (r_state == RD_WAIT) r_word <= ReadData;
    end
`else
    assign w_wdata = r_wdata;
`endif

    assign req_ready  = (r_state == IDLE) & rst_n;
    assign MemRead    = (r_state == RD_ISSUE) | (r_state == RD_WAIT);
    assign MemWrite   = (r_state == WRITE);
    assign Address    = r_addr >> 2;
    assign WriteData  = MemWrite ? w_wdata : '0;
    assign resp_valid = (r_state == DONE);
    assign resp_rdata = resp_valid ? r_rdata : '0;
    assign resp_err   = resp_valid & r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Next state: errors skip memory, word stores skip the read, everything else reads first.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_hs) w_next = w_err ? DONE : (req_write & req_size[1]) ? WRITE : RD_ISSUE;
            RD_ISSUE: w_next = RD_WAIT;
            RD_WAIT:  w_next = r_write ? WRITE : DONE;
            WRITE:    w_next = DONE;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Register the request at acceptance; capture extended load data at the end of RD_WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_hs) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_rdata <= '0;
                r_size  <= req_size;
                r_uns   <= req_unsigned;
                r_write <= req_write;
                r_err   <= w_err;
            end
            if (r_state == RD_WAIT && !r_write) r_rdata <= w_ext;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit (RMW cases follow LSU_RMW_EN).
module tb_load_store_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, MemRead, MemWrite;
    logic [31:0] resp_rdata, Address, WriteData, ReadData, rd_q;
    logic [31:0] mem [0:511];
    logic [31:0] m4;
    logic        seen_wr, seen_rv;
    int          n_pass = 0, n_fail = 0;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic [8:0]  rdm;
        logic [8:0]  wrm;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32), .DEPTH(512)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .MemRead(MemRead),
        .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
    );

    // Word memory with one-cycle registered read.
    always @(posedge clk) begin
        if (MemWrite) mem[Address[8:0]] <= WriteData;
        if (MemRead) rd_q <= mem[Address[8:0]];
    end
    assign ReadData = rd_q;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input int lat,
                          input logic [31:0] rdata, input logic err,
                          input logic [8:0] rdm, input logic [8:0] wrm);
        exp_t        e;
        logic [8:0]  grd = '0, gwr = '0;
        int          glat = 0;
        logic [31:0] gdata = 'x;
        logic        gerr = 1'bx;
        wait_ready(tag);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        sb.push_back('{lat, rdata, err, rdm, wrm});
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c < 9; c++) begin
            grd[c] = MemRead;
            gwr[c] = MemWrite;
            if (resp_valid) begin
                glat = c; gdata = resp_rdata; gerr = resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        e = sb.pop_front();
        chk({tag, " latency"}, 32'(glat), 32'(e.lat));
        chk({tag, " rdata"}, gdata, e.rdata);
        chk({tag, " err"}, 32'(gerr), 32'(e.err));
        chk({tag, " MemRead cycles"}, 32'(grd), 32'(e.rdm));
        chk({tag, " MemWrite cycles"}, 32'(gwr), 32'(e.wrm));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst MemRead", 32'(MemRead), 32'd0);
        chk("rst MemWrite", 32'(MemWrite), 32'd0);
        chk("rst Address", Address, 32'd0);
        chk("rst WriteData", WriteData, 32'd0);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst resp_err", 32'(resp_err), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rst release ready", 32'(req_ready), 32'd1);

        do_req("st_w", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 0, 9'b0, 9'b10);
        m4 = 32'hDEADBEEF;
        chk("mem4 after st_w", mem[4], m4);
        do_req("ld_w", 0, 2'b10, 0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 0, 9'b110, 9'b0);
`ifdef LSU_RMW_EN
        do_req("st_b", 1, 2'b00, 0, 32'h11, 32'h1234565A, 4, 32'h0, 0, 9'b110, 9'b1000);
        m4 = 32'hDEAD5AEF;
        chk("mem4 after st_b", mem[4], m4);
`else
        do_req("st_h rejected", 1, 2'b01, 0, 32'h10, 32'h1234, 1, 32'h0, 1, 9'b0, 9'b0);
        do_req("st_b rejected", 1, 2'b00, 0, 32'h11, 32'h5A, 1, 32'h0, 1, 9'b0, 9'b0);
        chk("mem4 after rejected", mem[4], m4);
`endif
        do_req("ld_b_s @13", 0, 2'b00, 0, 32'h13, 32'h0, 3, 32'hFFFFFFDE, 0, 9'b110, 9'b0);
        do_req("ld_b_u @13", 0, 2'b00, 1, 32'h13, 32'h0, 3, 32'h000000DE, 0, 9'b110, 9'b0);
        do_req("ld_h_s @12", 0, 2'b01, 0, 32'h12, 32'h0, 3, 32'hFFFFDEAD, 0, 9'b110, 9'b0);
        do_req("ld_h_u @12", 0, 2'b01, 1, 32'h12, 32'h0, 3, 32'h0000DEAD, 0, 9'b110, 9'b0);
        do_req("ld_b_u @10", 0, 2'b00, 1, 32'h10, 32'h0, 3, 32'h000000EF, 0, 9'b110, 9'b0);
`ifdef LSU_RMW_EN
        do_req("ld_b_s @11", 0, 2'b00, 0, 32'h11, 32'h0, 3, 32'h0000005A, 0, 9'b110, 9'b0);
        do_req("ld_h_s @10", 0, 2'b01, 0, 32'h10, 32'h0, 3, 32'h00005AEF, 0, 9'b110, 9'b0);
        do_req("st_h @12", 1, 2'b01, 0, 32'h12, 32'h9999CAFE, 4, 32'h0, 0, 9'b110, 9'b1000);
        m4 = 32'hCAFE5AEF;
        chk("mem4 after st_h", mem[4], m4);
`else
        do_req("ld_b_s @11", 0, 2'b00, 0, 32'h11, 32'h0, 3, 32'hFFFFFFBE, 0, 9'b110, 9'b0);
        do_req("ld_h_s @10", 0, 2'b01, 0, 32'h10, 32'h0, 3, 32'hFFFFBEEF, 0, 9'b110, 9'b0);
`endif
        do_req("ld_h misaligned", 0, 2'b01, 0, 32'h13, 32'h0, 1, 32'h0, 1, 9'b0, 9'b0);
        do_req("ld_w out of range", 0, 2'b10, 0, 32'h800, 32'h0, 1, 32'h0, 1, 9'b0, 9'b0);
        do_req("ld size 11", 0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0, 1, 9'b0, 9'b0);
        do_req("ld_w misaligned", 0, 2'b10, 0, 32'h12, 32'h0, 1, 32'h0, 1, 9'b0, 9'b0);
        do_req("st_w misaligned", 1, 2'b10, 0, 32'h12, 32'h11111111, 1, 32'h0, 1, 9'b0, 9'b0);
        chk("mem4 after err st", mem[4], m4);
        do_req("st_w last word", 1, 2'b10, 0, 32'h7FC, 32'h0BADF00D, 2, 32'h0, 0, 9'b0, 9'b10);
        chk("mem511", mem[511], 32'h0BADF00D);
        do_req("ld_w last word", 0, 2'b10, 0, 32'h7FC, 32'h0, 3, 32'h0BADF00D, 0, 9'b110, 9'b0);

        wait_ready("mid rst");
`ifdef LSU_RMW_EN
        req_write = 1'b1; req_size = 2'b00; req_addr = 32'h11; req_wdata = 32'hA5;
`else
        req_write = 1'b0; req_size = 2'b00; req_addr = 32'h11; req_wdata = 32'h0;
`endif
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("mid rst RD_ISSUE MemRead", 32'(MemRead), 32'd1);
        @(posedge clk);
        #1 chk("mid rst RD_WAIT MemRead", 32'(MemRead), 32'd1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid rst MemRead", 32'(MemRead), 32'd0);
        chk("mid rst Address", Address, 32'd0);
        chk("mid rst req_ready", 32'(req_ready), 32'd0);
        seen_wr = MemWrite;
        seen_rv = resp_valid;
        @(posedge clk);
        #1 seen_wr |= MemWrite; seen_rv |= resp_valid;
        @(negedge clk) rst_n = 1'b1;
        #1 chk("post rst req_ready", 32'(req_ready), 32'd1);
        repeat (4) begin
            @(posedge clk);
            #1 seen_wr |= MemWrite; seen_rv |= resp_valid;
        end
        chk("mid rst no MemWrite", 32'(seen_wr), 32'd0);
        chk("mid rst no resp_valid", 32'(seen_rv), 32'd0);
        chk("mid rst mem4", mem[4], m4);
        do_req("ld_w after rst", 0, 2'b10, 0, 32'h10, 32'h0, 3, m4, 0, 9'b110, 9'b0);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end
endmodule
